// File: rtl/stack_seq_ctrl_pkg.sv
// Shared constants for the stack sequencer: op codes, FSM encodings and per-op word counts.
// Single-word pushes/pops take one cycle; CALL/RET take two; INT/RTI take three.
package stack_seq_ctrl_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_INT  = 3'd5;
   localparam logic [2:0] OP_RTI  = 3'd6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WORD1 = 2'd1;
   localparam logic [1:0] ST_WORD2 = 2'd2;

   localparam logic [31:0] STACK_TOP_DEFAULT = 32'd2047;

   // Zero means "not a stack op" (NOP and the reserved code 7).
   function automatic logic [1:0] word_count(input logic [2:0] op);
      case (op)
         OP_PUSH, OP_POP: word_count = 2'd1;
         OP_CALL, OP_RET: word_count = 2'd2;
         OP_INT,  OP_RTI: word_count = 2'd3;
         default:         word_count = 2'd0;
      endcase
   endfunction

   function automatic logic is_push_op(input logic [2:0] op);
      is_push_op = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
   endfunction

endpackage

// File: rtl/stack_seq_ctrl_ptr.sv
// 32-bit stack pointer with +/-1 step and acceptance-time bounds checks for an n-word op.
// Step takes effect at the next edge; bounds outputs are combinational from the current SP.
module stack_ptr_reg
   import stack_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] STACK_TOP   = STACK_TOP_DEFAULT,
   parameter logic [31:0] STACK_LIMIT = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_dn,
   input  logic        step_up,
   input  logic [1:0]  n_words,
   output logic [31:0] sp_q,
   output logic        push_rej,
   output logic        pop_rej
);

   logic [31:0] sp_d;

   always_comb begin
      sp_d = sp_q;
      if (step_dn) begin
         sp_d = sp_q - 32'd1;
      end else if (step_up) begin
         sp_d = sp_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= STACK_TOP;
      end else begin
         sp_q <= sp_d;
      end
   end

   // SP-(n-1) < LIMIT rewritten as SP+1 < LIMIT+n so nothing underflows.
   assign push_rej = ({1'b0, sp_q} + 33'd1) < ({1'b0, STACK_LIMIT} + 33'(n_words));
   assign pop_rej  = ({1'b0, sp_q} + 33'(n_words)) > {1'b0, STACK_TOP};

endmodule

// File: rtl/stack_seq_ctrl.sv
// Sequences one stack-class op into 16-bit memory accesses, one word per cycle, word 0 in the accept cycle.
// Stalls upstream on every word but the last; rejected ops pulse ovf/unf and never stall.
module stack_seq_ctrl
   import stack_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] STACK_TOP   = STACK_TOP_DEFAULT,
   parameter logic [31:0] STACK_LIMIT = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid_in,
   input  logic [2:0]  op_code_in,
   input  logic [31:0] PC_in,
   input  logic [2:0]  flags_in,
   input  logic [15:0] Rdst_val_in,
   input  logic [15:0] mem_rdata_in,
   output logic [31:0] mem_addr_out,
   output logic [15:0] mem_wdata_out,
   output logic        mem_write_out,
   output logic        mem_read_out,
   output logic [31:0] SP_val_out,
   output logic        stall_out,
   output logic [15:0] pop_data_out,
   output logic        pop_valid_out,
   output logic        POP_PC_sgn_out,
   output logic [31:0] POP_PC_addr_out,
   output logic        POP_flags_sgn_out,
   output logic [2:0]  POP_flags_val_out,
   output logic        stack_ovf_out,
   output logic        stack_unf_out
);

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] temp_hi_q, temp_hi_d;
   logic [2:0]  temp_flags_q, temp_flags_d;

   logic [2:0]  cur_op;
   logic [1:0]  n_words;
   logic [1:0]  widx;
   logic        is_push, accept, rej, active, last;
   logic        push_rej, pop_rej;

   stack_ptr_reg #(
      .STACK_TOP   (STACK_TOP),
      .STACK_LIMIT (STACK_LIMIT)
   ) u_sp (
      .clk      (clk),
      .reset    (reset),
      .step_dn  (active & is_push),
      .step_up  (active & ~is_push),
      .n_words  (n_words),
      .sp_q     (SP_val_out),
      .push_rej (push_rej),
      .pop_rej  (pop_rej)
   );

   always_comb begin
      cur_op  = (state_q == ST_IDLE) ? op_code_in : op_q;
      n_words = word_count(cur_op);
      is_push = is_push_op(cur_op);
      widx    = state_q;
      accept  = ~reset & (state_q == ST_IDLE) & op_valid_in & (n_words != 2'd0);
      rej     = accept & (is_push ? push_rej : pop_rej);
      // Reset gates every strobe so an aborted op cannot touch memory in the reset cycle.
      active  = ~reset & ((state_q == ST_IDLE) ? (accept & ~rej) : 1'b1);
      last    = (widx == n_words - 2'd1);

      state_d = ST_IDLE;
      if (active && !last) begin
         state_d = widx + 2'd1;
      end
      op_d = accept ? op_code_in : op_q;

      temp_hi_d    = temp_hi_q;
      temp_flags_d = temp_flags_q;
      if (active && (((cur_op == OP_RET) && (widx == 2'd0)) ||
                     ((cur_op == OP_RTI) && (widx == 2'd1)))) begin
         temp_hi_d = mem_rdata_in;
      end
      if (active && (cur_op == OP_RTI) && (widx == 2'd0)) begin
         temp_flags_d = mem_rdata_in[15:13];
      end

      mem_addr_out  = 32'd0;
      mem_wdata_out = 16'd0;
      mem_write_out = active & is_push;
      mem_read_out  = active & ~is_push;
      if (active) begin
         mem_addr_out = is_push ? SP_val_out : SP_val_out + 32'd1;
      end
      if (active && is_push) begin
         if (cur_op == OP_PUSH) begin
            mem_wdata_out = Rdst_val_in;
         end else begin
            case (widx)
               2'd0:    mem_wdata_out = PC_in[15:0];
               2'd1:    mem_wdata_out = PC_in[31:16];
               default: mem_wdata_out = {flags_in, 13'b0};
            endcase
         end
      end

      stall_out     = active & ~last;
      pop_valid_out = active & (cur_op == OP_POP);
      pop_data_out  = pop_valid_out ? mem_rdata_in : 16'd0;

      POP_PC_sgn_out    = active & last & ((cur_op == OP_RET) || (cur_op == OP_RTI));
      POP_PC_addr_out   = POP_PC_sgn_out ? {temp_hi_q, mem_rdata_in} : 32'd0;
      POP_flags_sgn_out = POP_PC_sgn_out & (cur_op == OP_RTI);
      POP_flags_val_out = POP_flags_sgn_out ? temp_flags_q : 3'd0;

      stack_ovf_out = rej & is_push;
      stack_unf_out = rej & ~is_push;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_NOP;
         temp_hi_q    <= 16'd0;
         temp_flags_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         temp_hi_q    <= temp_hi_d;
         temp_flags_q <= temp_flags_d;
      end
   end

endmodule
